// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full adder, LSB first, WIDTH cycles per add.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module structural_full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p_s;
    logic g_s;
    logic t_s;

    assign p_s  = x ^ y;
    assign g_s  = x & y;
    assign t_s  = p_s & cin;
    assign s    = p_s ^ cin;
    assign cout = g_s | t_s;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] res_cat_s;
    logic [WIDTH-1:0] b_load_s;
    logic             cin_load_s;

    structural_full_adder u_fa (
        .x    (op_a_q[0]),
        .y    (op_b_q[0]),
        .cin  (carry_q),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Operand B and initial carry as loaded on an accepted start (a - b is a + ~b + 1).
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load_s   = ~b;
            cin_load_s = 1'b1;
        end else begin
            b_load_s   = b;
            cin_load_s = carryin;
        end
`else
        b_load_s   = b;
        cin_load_s = carryin;
`endif
    end

    assign res_cat_s = {fa_sum_s, res_q};

    // Next-state, datapath shifting and registered-output update.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b_load_s;
                    carry_d = cin_load_s;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                res_d   = res_cat_s[WIDTH-1:1];
                carry_d = fa_cout_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this slice
                    sum_d   = res_cat_s;
                    cout_d  = fa_cout_s;
                    ovf_d   = carry_q ^ fa_cout_s;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;

endmodule
